// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: program counter, instruction-memory address and
// IF/ID pipeline register. It handles the hazard freeze and the execute-stage
// branch redirect/flush.
// Optional performance counters are enabled by defining IF_FETCH_PERF_CNT_EN.
module if_fetch_stage #(
  parameter int unsigned         INST_LEN = 32,
  parameter logic [INST_LEN-1:0] RESET_PC = '0,
  parameter int unsigned         PC_STEP  = 4,
  parameter logic [INST_LEN-1:0] NOP_WORD = 32'hE000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                freeze,
  input  logic                branch_taken,
  input  logic [INST_LEN-1:0] branch_address,
  output logic [INST_LEN-1:0] imem_address,
  input  logic [INST_LEN-1:0] imem_instruction,
  output logic [INST_LEN-1:0] if_pc,
  output logic [INST_LEN-1:0] if_instruction,
`ifdef IF_FETCH_PERF_CNT_EN
  output logic [31:0]         fetch_count,
  output logic [31:0]         stall_count,
  output logic [31:0]         flush_count,
`endif
  output logic                if_valid
);

  localparam logic [INST_LEN-1:0] PcStep = INST_LEN'(PC_STEP);

  logic [INST_LEN-1:0] pc_q, pc_d;
  logic [INST_LEN-1:0] pc_plus_step;
  logic [INST_LEN-1:0] if_pc_q, if_pc_d;
  logic [INST_LEN-1:0] if_instr_q, if_instr_d;
  logic                if_valid_q, if_valid_d;
  logic                load_fetch;

  // Sequential PC increment; wraps silently at the top of the address space.
  assign pc_plus_step = pc_q + PcStep;
  assign load_fetch   = !branch_taken && !freeze;

  // Next PC and IF/ID contents: branch beats freeze, freeze beats fetch.
  always_comb begin
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    if (branch_taken) begin
      // Targets are always word-aligned; low address bits are dropped.
      pc_d       = {branch_address[INST_LEN-1:2], 2'b00};
      if_pc_d    = '0;
      if_instr_d = NOP_WORD;
      if_valid_d = 1'b0;
    end else if (!freeze) begin
      pc_d       = pc_plus_step;
      if_pc_d    = pc_plus_step;
      if_instr_d = imem_instruction;
      if_valid_d = 1'b1;
    end
  end

  // PC and IF/ID state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= NOP_WORD;
      if_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign imem_address   = pc_q;
  assign if_pc          = if_pc_q;
  assign if_instruction = if_instr_q;
  assign if_valid       = if_valid_q;

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Event counters; each wraps naturally at 2^32.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (load_fetch)              fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (freeze && !branch_taken) stall_cnt_d = stall_cnt_q + 32'd1;
    if (branch_taken)            flush_cnt_d = flush_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  // Only the counters consume this.
  logic unused_load_fetch;
  assign unused_load_fetch = load_fetch;
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the 32-bit ARM pipeline. It holds the program counter and drives the byte address into the combinational instruction memory. It captures the returned instruction word into the IF/ID pipeline register for the decode stage. It also applies the hazard-unit freeze and the branch redirect/flush from the execute stage.

Parameters:
INST_LEN, 32, width of the PC, the instruction memory address and the instruction word
RESET_PC, 32'h00000000, PC value loaded on reset; must be word-aligned
PC_STEP, 4, byte increment per sequential fetch
NOP_WORD, 32'hE0000000, instruction inserted into IF/ID on reset and flush (AL-condition AND R0,R0,R0)

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
freeze  in  1  hazard stall: hold PC and the IF/ID register
branch_taken  in  1  redirect request from execute; also flushes IF/ID
branch_address  in  INST_LEN  branch target byte address
imem_address  out  INST_LEN  byte address to instruction memory; equals the PC
imem_instruction  in  INST_LEN  word returned by memory in the same cycle
if_pc  out  INST_LEN  registered PC+4 of the captured instruction
if_instruction  out  INST_LEN  registered instruction to decode
if_valid  out  1  registered; 1 = if_instruction is a real fetch, 0 = bubble

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low; the polarity and synchronicity are fixed.
- Reset values (applied immediately when rst_n falls, not on the next edge): pc=RESET_PC, if_pc=0, if_instruction=NOP_WORD, if_valid=0.
- imem_address = pc. It is combinational from the PC register and has no other logic in the path.
- PC update on each rising edge, in priority order:
  1. branch_taken=1: pc <= {branch_address[31:2], 2'b00}. Target low two bits are always forced to 0.
  2. freeze=1: pc holds.
  3. Otherwise: pc <= pc + PC_STEP, modulo 2^INST_LEN. 0xFFFFFFFC wraps to 0x00000000 with no flag.
- IF/ID register update on each rising edge, in priority order:
  1. branch_taken=1: if_instruction <= NOP_WORD, if_pc <= 0, if_valid <= 0. This flushes the wrong-path fetch.
  2. freeze=1: all three outputs hold their current values, whether or not the held entry is a bubble.
  3. Otherwise: if_instruction <= imem_instruction, if_pc <= pc + PC_STEP, if_valid <= 1.
- Branch beats freeze when both are asserted in the same cycle.
- Latency:
  - The instruction at address A appears on if_instruction one edge after imem_address==A.
  - After a taken branch there is exactly one bubble cycle (if_valid=0).
  - On the following edge the target instruction is captured.
- First edge after reset release: captures the word at RESET_PC with if_valid=1, unless freeze or branch_taken is asserted.
- freeze held for N cycles: imem_address, if_pc, if_instruction and if_valid are constant for all N cycles. Fetch resumes at the same PC on the first edge with freeze=0; no instruction is lost or duplicated.
- No state machine beyond the PC and IF/ID registers. The block does not itself decode or check imem_instruction.

Optional Feature:
Macro IF_FETCH_PERF_CNT_EN.
- Defined:
  - Extra outputs fetch_count[31:0], stall_count[31:0] and flush_count[31:0], all registered and reset to 0 asynchronously.
  - fetch_count increments on an edge that loads a valid instruction.
  - stall_count increments on an edge with freeze=1 and branch_taken=0.
  - flush_count increments on an edge with branch_taken=1.
  - Each counter wraps at 2^32.
- Undefined: the three ports and all counter logic are absent; behaviour is otherwise identical.

Test Plan:
1. Reset with RESET_PC=0, then release; memory returns word = address|0xA5000000 -> edges 1..4 give if_instruction 0xA5000000, 0xA5000004, 0xA5000008, 0xA500000C with if_pc 4, 8, 12, 16 and if_valid=1.
2. freeze=1 for 3 cycles while imem_address=0x8 -> imem_address stays 0x8; if_pc=8 and if_instruction=0xA5000004 held; after release the next capture is 0xA5000008 with if_pc=0xC.
3. branch_taken=1 with branch_address=0x40 while pc=0x10 -> next edge gives imem_address=0x40, if_instruction=0xE0000000, if_valid=0; the following edge gives if_instruction=0xA5000040, if_pc=0x44.
4. branch_taken=1 and freeze=1 together with branch_address=0x43 -> pc becomes 0x40 and the flush occurs; freeze is ignored for that edge.
5. RESET_PC=0xFFFFFFFC -> first capture has if_pc=0x00000000; imem_address then reads 0x00000000.
6. rst_n driven low mid-cycle during a running fetch -> pc=RESET_PC, if_valid=0 and if_instruction=0xE0000000 before the next clk edge; with IF_FETCH_PERF_CNT_EN defined, all counters also read 0.
